// File: rtl/mcpu_core_regfile_sb.sv
// mcpu_core_regfile_sb: multi-lane register file with per-register pending-write scoreboard and predicate bank.
// Build option MCPU_CORE_RF_BYPASS_EN forwards same-cycle writeback data and releases into the read ports.

module mcpu_core_regfile_sb_cnt #(
  parameter int NLANES = 4,
  parameter int CNTW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NLANES-1:0] claim_hit,
  input  logic [NLANES-1:0] rel_hit,
  output logic [CNTW-1:0]   cnt,
  output logic              full,
  output logic              err
);
  localparam int LW = $clog2(NLANES+1);
  localparam int SW = CNTW + LW + 1;
  localparam logic [CNTW-1:0] CMAX = '1;

  logic [LW-1:0]   nclaim;
  logic [LW-1:0]   nrel;
  logic [SW-1:0]   sum;
  logic [CNTW-1:0] cnt_nxt;

  always_comb begin
    nclaim = '0;
    nrel   = '0;
    for (int l = 0; l < NLANES; l++) begin
      nclaim = nclaim + LW'(claim_hit[l]);
      nrel   = nrel + LW'(rel_hit[l]);
    end
    // one spare bit of headroom: MSB set means the net count went below zero
    sum     = SW'(cnt) + SW'(nclaim) - SW'(nrel);
    cnt_nxt = sum[CNTW-1:0];
    err     = 1'b0;
    if (sum[SW-1]) begin
      cnt_nxt = '0;
      err     = 1'b1;
    end else if (sum > SW'(CMAX)) begin
      cnt_nxt = CMAX;
      err     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

  assign full = (cnt == CMAX);
endmodule

module mcpu_core_regfile_sb_rd #(
  parameter int NLANES = 4,
  parameter int NREGS  = 32,
  parameter int WIDTH  = 32,
  parameter int CNTW   = 2,
  parameter int RB     = 5
) (
  input  logic [RB-1:0]                  rs_num,
  input  logic [RB-1:0]                  rt_num,
  input  logic [NREGS-1:0][WIDTH-1:0]    mem,
  input  logic [NREGS-1:0][CNTW-1:0]     cnt,
`ifdef MCPU_CORE_RF_BYPASS_EN
  input  logic [NLANES-1:0]              wb_we,
  input  logic [NLANES-1:0]              wb_rel,
  input  logic [NLANES-1:0][RB-1:0]      wb_num,
  input  logic [NLANES-1:0][WIDTH-1:0]   wb_data,
`endif
  output logic [WIDTH-1:0]               rs_data,
  output logic [WIDTH-1:0]               rt_data,
  output logic                           rs_busy,
  output logic                           rt_busy
);
  localparam int CW = CNTW + $clog2(NLANES+1);

  function automatic logic [WIDTH-1:0] data_of(input logic [RB-1:0] src);
    data_of = mem[src];
`ifdef MCPU_CORE_RF_BYPASS_EN
    // walk high to low so the lowest matching lane is the one left standing
    for (int l = NLANES-1; l >= 0; l--)
      if (wb_we[l] && wb_num[l] == src) data_of = wb_data[l];
`endif
  endfunction

  function automatic logic busy_of(input logic [RB-1:0] src);
`ifdef MCPU_CORE_RF_BYPASS_EN
    logic [CW-1:0] nrel;
    nrel = '0;
    for (int l = 0; l < NLANES; l++)
      nrel = nrel + CW'(wb_rel[l] && wb_num[l] == src);
    busy_of = CW'(cnt[src]) > nrel;
`else
    busy_of = (cnt[src] != '0);
`endif
  endfunction

  assign rs_data = data_of(rs_num);
  assign rt_data = data_of(rt_num);
  assign rs_busy = busy_of(rs_num);
  assign rt_busy = busy_of(rt_num);
endmodule

module mcpu_core_regfile_sb #(
  parameter int NLANES = 4,
  parameter int NREGS  = 32,
  parameter int WIDTH  = 32,
  parameter int NPREDS = 3,
  parameter int CNTW   = 2,
  localparam int RB    = $clog2(NREGS)
) (
  input  logic                    clkrst_core_clk,
  input  logic                    clkrst_core_rst,
  input  logic [NLANES*RB-1:0]    d2rf_rs_num,
  input  logic [NLANES*RB-1:0]    d2rf_rt_num,
  output logic [NLANES*WIDTH-1:0] rf2d_rs_data,
  output logic [NLANES*WIDTH-1:0] rf2d_rt_data,
  output logic [NLANES-1:0]       rf2d_rs_busy,
  output logic [NLANES-1:0]       rf2d_rt_busy,
  input  logic [NLANES-1:0]       d2rf_claim_vld,
  input  logic [NLANES*RB-1:0]    d2rf_claim_num,
  input  logic [NLANES-1:0]       wb2rf_rd_we,
  input  logic [NLANES-1:0]       wb2rf_pred_we,
  input  logic [NLANES*RB-1:0]    wb2rf_rd_num,
  input  logic [NLANES*WIDTH-1:0] wb2rf_rd_data,
  input  logic [NLANES-1:0]       wb2rf_release,
  output logic [NPREDS-1:0]       preds,
  output logic                    rf2d_claim_full,
  output logic                    rf2d_sb_err
);
  localparam int PB = $clog2(NPREDS+1);
  localparam logic [PB:0] NPREDS_W = (PB+1)'(NPREDS);

  logic [NLANES-1:0][RB-1:0]    rs_n, rt_n, cl_n, wb_n;
  logic [NLANES-1:0][WIDTH-1:0] wb_d, rs_d, rt_d;
  logic [NLANES-1:0]            rs_b, rt_b;

  logic [NREGS-1:0][WIDTH-1:0]  mem, mem_nxt;
  logic [NREGS-1:0][CNTW-1:0]   cnt;
  logic [NREGS-1:0]             full, cnt_err;
  logic [NPREDS-1:0]            pred_q, pred_nxt;
  logic                         sb_err_q;

  assign rs_n = d2rf_rs_num;
  assign rt_n = d2rf_rt_num;
  assign cl_n = d2rf_claim_num;
  assign wb_n = wb2rf_rd_num;
  assign wb_d = wb2rf_rd_data;

  // lowest lane wins on collisions: later (lower) lanes overwrite earlier ones
  always_comb begin
    mem_nxt  = mem;
    pred_nxt = pred_q;
    for (int l = NLANES-1; l >= 0; l--) begin
      if (wb2rf_rd_we[l]) mem_nxt[wb_n[l]] = wb_d[l];
      if (wb2rf_pred_we[l] && ({1'b0, wb_n[l][PB-1:0]} < NPREDS_W))
        pred_nxt[wb_n[l][PB-1:0]] = wb_d[l][0];
    end
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      mem      <= '0;
      pred_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      mem      <= mem_nxt;
      pred_q   <= pred_nxt;
      sb_err_q <= sb_err_q | (|cnt_err);
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    logic [NLANES-1:0] claim_hit, rel_hit;
    for (genvar l = 0; l < NLANES; l++) begin : g_hit
      assign claim_hit[l] = d2rf_claim_vld[l] && (cl_n[l] == RB'(r));
      assign rel_hit[l]   = wb2rf_release[l] && (wb_n[l] == RB'(r));
    end
    mcpu_core_regfile_sb_cnt #(.NLANES(NLANES), .CNTW(CNTW)) u_cnt (
      .clk       (clkrst_core_clk),
      .rst       (clkrst_core_rst),
      .claim_hit (claim_hit),
      .rel_hit   (rel_hit),
      .cnt       (cnt[r]),
      .full      (full[r]),
      .err       (cnt_err[r])
    );
  end

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    mcpu_core_regfile_sb_rd #(
      .NLANES(NLANES), .NREGS(NREGS), .WIDTH(WIDTH), .CNTW(CNTW), .RB(RB)
    ) u_rd (
      .rs_num  (rs_n[l]),
      .rt_num  (rt_n[l]),
      .mem     (mem),
      .cnt     (cnt),
`ifdef MCPU_CORE_RF_BYPASS_EN
      .wb_we   (wb2rf_rd_we),
      .wb_rel  (wb2rf_release),
      .wb_num  (wb_n),
      .wb_data (wb_d),
`endif
      .rs_data (rs_d[l]),
      .rt_data (rt_d[l]),
      .rs_busy (rs_b[l]),
      .rt_busy (rt_b[l])
    );
  end

  // outputs are forced quiet while reset is held, including any bypass paths
  assign rf2d_rs_data    = clkrst_core_rst ? '0 : rs_d;
  assign rf2d_rt_data    = clkrst_core_rst ? '0 : rt_d;
  assign rf2d_rs_busy    = clkrst_core_rst ? '0 : rs_b;
  assign rf2d_rt_busy    = clkrst_core_rst ? '0 : rt_b;
  assign preds           = clkrst_core_rst ? '0 : pred_q;
  assign rf2d_claim_full = !clkrst_core_rst && (|full);
  assign rf2d_sb_err     = !clkrst_core_rst && sb_err_q;
endmodule

// File: tb/tb_mcpu_core_regfile_sb.sv
// Bench for mcpu_core_regfile_sb: table of write/read vectors plus hand sequences for scoreboard corners.
module tb_mcpu_core_regfile_sb;
  localparam int NL = 4, RB = 5, W = 32, NP = 3;
`ifdef MCPU_CORE_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NL*RB-1:0] rs_num, rt_num, claim_num, rd_num;
  logic [NL*W-1:0]  rs_data, rt_data, rd_data;
  logic [NL-1:0]    rs_busy, rt_busy, claim_vld, rd_we, pred_we, rel;
  logic [NP-1:0]    preds;
  logic             full, err;

  always #5 clk = ~clk;

  mcpu_core_regfile_sb #(.NLANES(NL), .NREGS(32), .WIDTH(W), .NPREDS(NP), .CNTW(2)) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .d2rf_rs_num     (rs_num),
    .d2rf_rt_num     (rt_num),
    .rf2d_rs_data    (rs_data),
    .rf2d_rt_data    (rt_data),
    .rf2d_rs_busy    (rs_busy),
    .rf2d_rt_busy    (rt_busy),
    .d2rf_claim_vld  (claim_vld),
    .d2rf_claim_num  (claim_num),
    .wb2rf_rd_we     (rd_we),
    .wb2rf_pred_we   (pred_we),
    .wb2rf_rd_num    (rd_num),
    .wb2rf_rd_data   (rd_data),
    .wb2rf_release   (rel),
    .preds           (preds),
    .rf2d_claim_full (full),
    .rf2d_sb_err     (err)
  );

  typedef struct { string nm; logic [31:0] v; } exp_t;
  typedef struct { int lane; logic [RB-1:0] num; logic [W-1:0] data; } vec_t;
  exp_t sbq[$];
  vec_t tbl[5];
  int checks = 0;
  int errors = 0;

  task automatic idle();
    rs_num = '0; rt_num = '0; claim_vld = '0; claim_num = '0;
    rd_we = '0; pred_we = '0; rel = '0; rd_num = '0; rd_data = '0;
  endtask
  task automatic next();
    @(posedge clk); #1; idle();
  endtask
  task automatic settle();
    #3;
  endtask
  task automatic push(input string nm, input logic [31:0] v);
    exp_t e;
    e.nm = nm; e.v = v;
    sbq.push_back(e);
  endtask
  task automatic check(input logic [31:0] act);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      e = sbq.pop_front();
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", e.nm, act, e.v);
      end
    end
  endtask

  task automatic wr(input int l, input logic [RB-1:0] n, input logic [W-1:0] d);
    rd_we[l] = 1'b1; rd_num[l*RB +: RB] = n; rd_data[l*W +: W] = d;
  endtask
  task automatic pw(input int l, input logic [RB-1:0] n, input logic b);
    pred_we[l] = 1'b1; rd_num[l*RB +: RB] = n; rd_data[l*W +: W] = {31'b0, b};
  endtask
  task automatic cl(input int l, input logic [RB-1:0] n);
    claim_vld[l] = 1'b1; claim_num[l*RB +: RB] = n;
  endtask
  task automatic rl(input int l, input logic [RB-1:0] n);
    rel[l] = 1'b1; rd_num[l*RB +: RB] = n;
  endtask
  task automatic rs(input int l, input logic [RB-1:0] n);
    rs_num[l*RB +: RB] = n;
  endtask
  task automatic rt(input int l, input logic [RB-1:0] n);
    rt_num[l*RB +: RB] = n;
  endtask
  function automatic logic [31:0] rsd(input int l);
    return rs_data[l*W +: W];
  endfunction
  function automatic logic [31:0] rtd(input int l);
    return rt_data[l*W +: W];
  endfunction

  task automatic check_quiet(input string tag);
    push({tag, "_rs_data"}, 32'h0); check(rsd(0));
    push({tag, "_busy"}, 32'h0);    check(32'({rs_busy, rt_busy}));
    push({tag, "_preds"}, 32'h0);   check(32'(preds));
    push({tag, "_full"}, 32'h0);    check(32'(full));
    push({tag, "_err"}, 32'h0);     check(32'(err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 5'd1,  32'h1111_0001};
    tbl[1] = '{1, 5'd10, 32'hA5A5_5A5A};
    tbl[2] = '{3, 5'd31, 32'hFFFF_FFFF};
    tbl[3] = '{2, 5'd0,  32'h0000_0077};
    tbl[4] = '{1, 5'd20, 32'h8000_0000};

    idle();
    #1; rs(0, 5'd5); settle();
    check_quiet("in_reset");
    next(); next();
    rst = 1'b0; rs(0, 5'd5); settle();
    check_quiet("post_reset");

    // r5 written on lane 2, read on lane 0
    next(); wr(2, 5'd5, 32'hDEAD_BEEF); rs(0, 5'd5); settle();
    push("r5_same_cycle", BYP ? 32'hDEAD_BEEF : 32'h0); check(rsd(0));
    next(); rs(0, 5'd5); rt(0, 5'd6); rs(1, 5'd31); settle();
    push("r5_next_cycle", 32'hDEAD_BEEF); check(rsd(0));
    push("r6_untouched", 32'h0);          check(rtd(0));
    push("r31_untouched", 32'h0);         check(rsd(1));

    for (int i = 0; i < 5; i++) begin
      next(); wr(tbl[i].lane, tbl[i].num, tbl[i].data);
      push("tbl_rs", tbl[i].data); push("tbl_rt", tbl[i].data);
      next(); rs(i % NL, tbl[i].num); rt((i + 1) % NL, tbl[i].num); settle();
      check(rsd(i % NL)); check(rtd((i + 1) % NL));
    end

    // collisions: lowest lane wins for data and predicates
    next(); wr(0, 5'd7, 32'h11); wr(3, 5'd7, 32'h33); pw(1, 5'd1, 1'b1); pw(2, 5'd1, 1'b0);
    push("r7_collision", 32'h11); push("pred_collision", 32'h2);
    next(); rs(2, 5'd7); settle();
    check(rsd(2)); check(32'(preds));
    next(); pw(0, 5'd3, 1'b1); pw(1, 5'd4, 1'b1);
    push("pred_range", 32'h3);
    next(); settle(); check(32'(preds));

    // claim r9, release with we=0
    next(); cl(0, 5'd9); rs(1, 5'd9); settle();
    push("r9_busy_claim_cycle", 32'h0); check(32'(rs_busy[1]));
    next(); rs(1, 5'd9); settle();
    push("r9_busy_next", 32'h1); check(32'(rs_busy[1]));
    next();
    next(); rl(2, 5'd9); rs(1, 5'd9); settle();
    push("r9_busy_release_cycle", BYP ? 32'h0 : 32'h1); check(32'(rs_busy[1]));
    next(); rs(1, 5'd9); settle();
    push("r9_busy_after", 32'h0); check(32'(rs_busy[1]));
    push("r9_data_kept", 32'h0);  check(rsd(1));

    // r4 double claim and netting
    next(); cl(0, 5'd4); cl(1, 5'd4);
    next(); rt(3, 5'd4); settle();
    push("r4_busy_cnt2", 32'h1); check(32'(rt_busy[3]));
    push("full_cnt2", 32'h0);    check(32'(full));
    next(); rl(3, 5'd4);
    next(); rt(3, 5'd4); settle();
    push("r4_busy_one_rel", 32'h1); check(32'(rt_busy[3]));
    next(); cl(0, 5'd4); rl(1, 5'd4); rt(3, 5'd4); settle();
    push("r4_busy_claim_rel", BYP ? 32'h0 : 32'h1); check(32'(rt_busy[3]));
    next(); rt(3, 5'd4); settle();
    push("r4_busy_net", 32'h1); check(32'(rt_busy[3]));
    next(); rl(0, 5'd4);
    next(); rt(3, 5'd4); settle();
    push("r4_busy_cleared", 32'h0); check(32'(rt_busy[3]));
    push("err_clean", 32'h0);       check(32'(err));

    // release at zero on r6
    next(); rl(2, 5'd6);
    next(); rs(0, 5'd6); settle();
    push("err_underflow", 32'h1);  check(32'(err));
    push("r6_busy_floor", 32'h0);  check(32'(rs_busy[0]));
    next(); cl(1, 5'd6);
    next(); rs(0, 5'd6); settle();
    push("r6_busy_from_zero", 32'h1); check(32'(rs_busy[0]));
    next(); cl(2, 5'd8);
    next(); rs(0, 5'd6); rs(1, 5'd8); settle();
    push("err_sticky", 32'h1); check(32'(err));
    push("r8_busy", 32'h1);    check(32'(rs_busy[1]));

    // reset with claims outstanding and a write in flight
    next(); rst = 1'b1; cl(0, 5'd8); wr(1, 5'd8, 32'h55);
    next(); rst = 1'b0; rs(0, 5'd6); rs(1, 5'd8); rs(2, 5'd5); settle();
    push("rst_busy", 32'h0);    check(32'({rs_busy, rt_busy}));
    push("rst_err", 32'h0);     check(32'(err));
    push("rst_r8_data", 32'h0); check(rsd(1));
    push("rst_r5_data", 32'h0); check(rsd(2));
    push("rst_preds", 32'h0);   check(32'(preds));

    // saturation on r3
    next(); cl(0, 5'd3); cl(1, 5'd3); cl(2, 5'd3); cl(3, 5'd3);
    next(); rs(0, 5'd3); settle();
    push("sat_full", 32'h1); check(32'(full));
    push("sat_err", 32'h1);  check(32'(err));
    push("sat_busy", 32'h1); check(32'(rs_busy[0]));
    next(); rl(0, 5'd3); rl(1, 5'd3);
    next(); rs(0, 5'd3); settle();
    push("sat_busy_cnt1", 32'h1); check(32'(rs_busy[0]));
    push("sat_full_cnt1", 32'h0); check(32'(full));
    next(); rl(2, 5'd3);
    next(); rs(0, 5'd3); settle();
    push("sat_busy_cnt0", 32'h0); check(32'(rs_busy[0]));
    push("sat_err_kept", 32'h1);  check(32'(err));

    // same-cycle write/read of r12 with a lane collision
    next(); wr(0, 5'd12, 32'h1234);
    next(); wr(1, 5'd12, 32'hCAFE); wr(3, 5'd12, 32'hBEEF); rs(2, 5'd12); settle();
    push("r12_same_cycle", BYP ? 32'hCAFE : 32'h1234); check(rsd(2));
    next(); rs(2, 5'd12); settle();
    push("r12_next_cycle", 32'hCAFE); check(rsd(2));

    next();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
